// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : rca4
// Description : 4-bit ripple-carry adder built from a chain of full adders.
//               Ports: x, y (addends), c_in (carry in), sum, c_out.
// Revision    : 1.0 - initial release
// ============================================================================
module rca4 (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       c_in,
  output logic [3:0] sum,
  output logic       c_out
);

  logic [4:0] w_c;

  assign w_c[0] = c_in;

  for (genvar i = 0; i < 4; i++) begin : g_bit
    assign sum[i]   = x[i] ^ y[i] ^ w_c[i];
    assign w_c[i+1] = (x[i] & y[i]) | (w_c[i] & (x[i] ^ y[i]));
  end

  assign c_out = w_c[4];

endmodule

// ============================================================================
// Module      : bin2bcd_seq
// Description : Iterative shift-and-add-3 (double dabble) binary-to-BCD
//               converter. One WIDTH-bit operand per start pulse; the packed
//               DIGITS-digit BCD result appears WIDTH cycles later.
//               Ports:
//                 clk     - system clock, rising edge
//                 reset_n - asynchronous active-low reset
//                 start   - conversion request, sampled only when idle
//                 bin     - unsigned binary operand, captured on acceptance
//                 busy    - high while a conversion is running
//                 done    - one-cycle pulse, bcd just updated
//                 bcd     - packed result, digit k at [4k+3:4k], k=0 = units
// Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int c_BCD_W = 4 * DIGITS;
  localparam int c_SR_W  = c_BCD_W + WIDTH;
  localparam int c_CNT_W = $clog2(WIDTH + 1);
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

  // Integration check: too few digits silently truncates the high-order result.
  if ((WIDTH < 4) || (WIDTH > 16) || ((10 ** DIGITS) <= ((2 ** WIDTH) - 1))) begin : g_param_check
    $error("bin2bcd_seq: illegal WIDTH/DIGITS combination");
  end

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_CONV = 1'b1
  } state_t;

  state_t               r_state;
  logic [c_SR_W-1:0]    r_sr;
  logic [c_CNT_W-1:0]   r_cnt;

  logic [c_SR_W-1:0]    w_adj;
  logic [c_SR_W-1:0]    w_shifted;
  logic [DIGITS-1:0]    w_cout;

  // Binary bits below the BCD field pass through uncorrected.
  assign w_adj[WIDTH-1:0] = r_sr[WIDTH-1:0];

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    logic [3:0] w_dig;
    logic [3:0] w_sum;

    assign w_dig = r_sr[WIDTH + 4*k +: 4];

    rca4 u_add3 (
      .x     (w_dig),
      .y     (4'b0011),
      .c_in  (1'b0),
      .sum   (w_sum),
      .c_out (w_cout[k])
    );

    assign w_adj[WIDTH + 4*k +: 4] = (w_dig >= 4'd5) ? w_sum : w_dig;
  end

  assign w_shifted = w_adj << 1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_sr    <= '0;
      r_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd     <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sr    <= {{c_BCD_W{1'b0}}, bin};
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= S_CONV;
          end
        end
        S_CONV: begin
          r_sr  <= w_shifted;
          r_cnt <= r_cnt + 1'b1;
          // Last iteration: publish the BCD field only now so bcd never
          // exposes partial results.
          if (r_cnt == c_LAST) begin
            bcd     <= w_shifted[c_SR_W-1 -: c_BCD_W];
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // A corrected digit is at most 9+3 = 12, so the add-3 never carries out.
  a_no_add3_carry: assert property (@(posedge clk) disable iff (!reset_n)
                                    w_cout == '0);

endmodule
`default_nettype wire

// File: tb/tb_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_bin2bcd_seq
// Description : Self-checking bench for bin2bcd_seq. Expected results are
//               queued when a conversion is requested and compared whenever
//               done pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bin2bcd_seq;

  localparam int c_WIDTH  = 8;
  localparam int c_DIGITS = 3;

  logic                    clk;
  logic                    reset_n;
  logic                    start;
  logic [c_WIDTH-1:0]      bin;
  logic                    busy;
  logic                    done;
  logic [4*c_DIGITS-1:0]   bcd;

  int n_chk  = 0;
  int n_pass = 0;
  int n_done = 0;
  logic [4*c_DIGITS-1:0] exp_q[$];

  bin2bcd_seq #(.WIDTH(c_WIDTH), .DIGITS(c_DIGITS)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .bin     (bin),
    .busy    (busy),
    .done    (done),
    .bcd     (bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [11:0] ref_bcd(input int v);
    ref_bcd = {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Scoreboard: every done pulse pops one expected result.
  always @(negedge clk) begin
    if (reset_n && done) begin
      n_done++;
      if (exp_q.size() == 0) check("unexpected_done", 32'(done), 32'd0);
      else check("bcd", 32'(bcd), 32'(exp_q.pop_front()));
      for (int k = 0; k < c_DIGITS; k++)
        check("digit_le9", 32'(bcd[4*k +: 4] <= 4'd9), 32'd1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_conv(input int v, input bit push);
    start = 1'b1;
    bin   = c_WIDTH'(v);
    if (push) exp_q.push_back(ref_bcd(v));
    tick();
    start = 1'b0;
    bin   = c_WIDTH'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) check("timeout", 32'(n), 32'd0);
  endtask

  initial begin
    int lo;
    int d0;
    reset_n = 1'b0;
    start   = 1'b0;
    bin     = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_bcd",  32'(bcd),  32'd0);
    tick();
    reset_n = 1'b1;
    tick();

    // 255: busy for exactly 8 cycles, then one done cycle.
    d0 = n_done;
    start_conv(255, 1'b1);
    for (int i = 0; i < c_WIDTH; i++) begin
      @(negedge clk);
      check("busy_255", 32'(busy), 32'd1);
      check("nodone_255", 32'(done), 32'd0);
    end
    @(negedge clk);
    check("busy_end_255", 32'(busy), 32'd0);
    check("done_255", 32'(done), 32'd1);
    tick();
    wait_idle();
    check("done_cnt_255", 32'(n_done - d0), 32'd1);

    // Separate conversions with hold check between them.
    start_conv(0, 1'b1);   wait_idle();
    repeat (3) tick();
    check("hold_000", 32'(bcd), 32'h000);
    start_conv(99, 1'b1);  wait_idle();
    repeat (3) tick();
    check("hold_099", 32'(bcd), 32'h099);
    start_conv(128, 1'b1); wait_idle();
    check("hold_128", 32'(bcd), 32'h128);

    // Start while busy is ignored.
    d0 = n_done;
    start_conv(200, 1'b1);
    tick(); tick();
    start = 1'b1; bin = 8'd17;
    tick();
    start = 1'b0;
    wait_idle();
    repeat (12) tick();
    check("busy_start_ignored_done", 32'(n_done - d0), 32'd1);
    check("busy_start_bcd", 32'(bcd), 32'h200);

    // Start held through the done cycle: second conversion accepted then.
    d0 = n_done;
    lo = 0;
    start = 1'b1; bin = 8'd45;
    exp_q.push_back(ref_bcd(45));
    tick();
    bin = 8'd67;
    exp_q.push_back(ref_bcd(67));
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      if (!busy) lo++;
      if (i == 8) begin
        check("b2b_first_bcd", 32'(bcd), 32'h045);
        @(posedge clk);
        #1 start = 1'b0;
      end
    end
    check("b2b_busy_low_cycles", 32'(lo), 32'd1);
    tick();
    wait_idle();
    check("b2b_done_cnt", 32'(n_done - d0), 32'd2);
    check("b2b_second_bcd", 32'(bcd), 32'h067);

    // Reset mid-conversion: immediate clear, no done afterwards.
    d0 = n_done;
    start_conv(250, 1'b0);
    repeat (3) tick();
    #2 reset_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_bcd",  32'(bcd),  32'd0);
    tick(); tick();
    reset_n = 1'b1;
    repeat (12) tick();
    check("arst_no_done", 32'(n_done - d0), 32'd0);
    check("arst_idle", 32'(busy), 32'd0);
    start_conv(9, 1'b1);
    wait_idle();
    check("arst_then_009", 32'(bcd), 32'h009);

    // Exhaustive sweep.
    d0 = n_done;
    for (int v = 0; v < 256; v++) begin
      start_conv(v, 1'b1);
      wait_idle();
    end
    check("sweep_done_cnt", 32'(n_done - d0), 32'd256);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
